// File: rtl/seq_alu_core.sv
// seq_alu_core: valid/ready ALU with registered result and flags, plus an iterative shift-add multiplier.
// Define SEQ_ALU_DIV_EN to turn op 111 into an iterative unsigned restoring divider.
module seq_alu_core #(
   parameter int WIDTH     = 32,
   parameter int SHAMT_LSB = 6,
   parameter int SHAMT_W   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             gt,
   output logic             overflow,
   output logic             negative
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_XOR = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_SLT = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
`ifdef SEQ_ALU_DIV_EN
   localparam logic [2:0] OP_DIV = 3'b111;
`endif
   localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

`ifdef SEQ_ALU_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
   typedef enum logic [0:0] {IDLE, MUL} state_t;
`endif

   state_t state_q, state_d;

   logic               accept;
   logic               op_multi;
   logic [SHAMT_W-1:0] iter_q;
   logic [WIDTH-1:0]   operand_q;
   logic [WIDTH-1:0]   acc_hi_q;
   logic [WIDTH-1:0]   acc_lo_q;

   logic               is_sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum_ext;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   sc_result;
   logic               sc_c, sc_v, sc_n, sc_z, sc_gt, sc_nz;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi_next;
   logic [WIDTH-1:0]   mul_lo_next;

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic               div_zero;
   logic [WIDTH-1:0]   div_hi_next;
   logic [WIDTH-1:0]   div_lo_next;
`endif

   // New work is taken only in IDLE and only if the output slot frees up on this edge.
   assign in_ready = !rst && (state_q == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

`ifdef SEQ_ALU_DIV_EN
   assign op_multi = (op == OP_MUL) || (op == OP_DIV);
`else
   assign op_multi = (op == OP_MUL);
`endif

   always_comb begin
      is_sub    = (op == OP_SUB);
      b_eff     = is_sub ? ~b : b;
      sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      shamt     = b[SHAMT_LSB +: SHAMT_W];
      sc_result = '0;
      sc_c      = 1'b0;
      sc_v      = 1'b0;
      sc_nz     = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            sc_result = sum_ext[WIDTH-1:0];
            sc_c      = sum_ext[WIDTH];
            sc_v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            sc_nz     = 1'b1;
         end
         OP_XOR: sc_result = a ^ b;
         OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL: sc_result = a << shamt;
         OP_SRL: sc_result = a >> shamt;
         default: sc_result = '0;
      endcase
      sc_n  = sc_nz && sc_result[WIDTH-1];
      sc_z  = sc_nz && (sc_result == '0);
      sc_gt = is_sub && (sc_n == sc_v) && !sc_z;
   end

   // One shift-add step: acc_lo holds the remaining multiplier bits, acc_hi the running high product.
   always_comb begin
      mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});
      mul_hi_next = mul_sum[WIDTH:1];
      mul_lo_next = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
   end

`ifdef SEQ_ALU_DIV_EN
   // One restoring step: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
   always_comb begin
      div_shift   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff    = div_shift - {1'b0, operand_q};
      div_ok      = !div_diff[WIDTH];
      div_zero    = (operand_q == '0);
      div_hi_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_lo_next = {acc_lo_q[WIDTH-2:0], div_ok};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && op == OP_MUL) begin
               state_d = MUL;
            end
`ifdef SEQ_ALU_DIV_EN
            if (accept && op == OP_DIV) begin
               state_d = DIV;
            end
`endif
         end
         MUL: begin
            if (iter_q == LAST_ITER) begin
               state_d = IDLE;
            end
         end
`ifdef SEQ_ALU_DIV_EN
         DIV: begin
            if (iter_q == LAST_ITER) begin
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Result/flag register and iterative datapath; a new result always overrides a drain on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         gt        <= 1'b0;
         overflow  <= 1'b0;
         negative  <= 1'b0;
         iter_q    <= '0;
         operand_q <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept && op_multi) begin
                  iter_q   <= '0;
                  acc_hi_q <= '0;
                  if (op == OP_MUL) begin
                     operand_q <= a;
                     acc_lo_q  <= b;
                  end else begin
                     operand_q <= b;
                     acc_lo_q  <= a;
                  end
               end else if (accept) begin
                  out_valid <= 1'b1;
                  result    <= sc_result;
                  carry     <= sc_c;
                  zero      <= sc_z;
                  gt        <= sc_gt;
                  overflow  <= sc_v;
                  negative  <= sc_n;
               end
            end
            MUL: begin
               acc_hi_q <= mul_hi_next;
               acc_lo_q <= mul_lo_next;
               iter_q   <= iter_q + SHAMT_W'(1);
               if (iter_q == LAST_ITER) begin
                  out_valid <= 1'b1;
                  result    <= mul_lo_next;
                  carry     <= (mul_hi_next != '0);
                  overflow  <= (mul_hi_next != '0);
                  zero      <= (mul_lo_next == '0);
                  negative  <= mul_lo_next[WIDTH-1];
                  gt        <= 1'b0;
               end
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
               acc_hi_q <= div_hi_next;
               acc_lo_q <= div_lo_next;
               iter_q   <= iter_q + SHAMT_W'(1);
               if (iter_q == LAST_ITER) begin
                  out_valid <= 1'b1;
                  result    <= div_zero ? '1 : div_lo_next;
                  carry     <= 1'b0;
                  overflow  <= div_zero;
                  zero      <= !div_zero && (div_lo_next == '0);
                  negative  <= div_zero || div_lo_next[WIDTH-1];
                  gt        <= 1'b0;
               end
            end
`endif
            default: begin
               iter_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU.
- Executes add, xor, sub, set-less-than, shifts and an iterative shift-add multiply, with registered result and NZCV/gt flags.
- Valid/ready on both sides, so the pipeline's execute stage can stall on multi-cycle ops instead of sitting in one long combinational path.

Parameters:
- WIDTH, 32: operand/result width; must be ≥ 8 and a power of 2.
- SHAMT_LSB, 6: LSB of the shift-amount field inside operand b.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  core can accept a request this cycle
- op  in  3  000 add, 001 xor, 010 sub, 011 slt, 100 sll, 101 srl, 110 mul, 111 reserved/div
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- carry, zero, gt, overflow, negative  out  1 each  flags

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE; out_valid, result and all flags = 0; multiplier registers cleared.
  - in_ready=0 while rst is high.
  - Reset mid-multiply abandons the op; no result is produced.
- Handshake:
  - Accept when in_valid & in_ready; op/a/b are captured on that edge.
  - Result transfers when out_valid & out_ready.
  - While out_valid & !out_ready: result and flags are held stable, and in_ready=0.
- in_ready = !rst & (state==IDLE) & (!out_valid | out_ready). Back-to-back single-cycle ops run at 1/cycle.
- States:
  - IDLE: a single-cycle op accepted at edge T gives out_valid high after edge T+1 (latency 1). mul → MUL.
  - MUL: WIDTH iterations of 1 bit/cycle; out_valid rises after the WIDTH-th iteration, i.e. accept→out_valid = WIDTH+1 edges; → IDLE.
  - in_ready=0 throughout MUL.
- Arithmetic (modulo 2^WIDTH):
  - add: a+b. C = carry-out; V = signed overflow.
  - sub: a+~b+1. C = carry-out (1 = no borrow); V = signed overflow.
  - N = result[WIDTH-1]; Z = (result==0) for add/sub/mul.
  - gt (sub only) = (N==V) & ~Z, i.e. signed a>b; 0 for every other op.
  - xor: a^b.
  - slt: unsigned a<b → 1, else 0.
  - sll/srl: a shifted by b[SHAMT_LSB +: SHAMT_W], zero fill. Requires SHAMT_LSB+SHAMT_W ≤ WIDTH.
  - xor/slt/sll/srl: all flags 0.
  - mul: unsigned; result = low WIDTH bits of the product. C=V=1 iff the upper WIDTH bits are nonzero; N and Z computed from result.
  - op 111 without the option: completes in 1 cycle with result=0, all flags 0.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined: op 111 = unsigned restoring divide via state DIV, WIDTH cycles, same latency and in_ready rules as MUL.
  - result = quotient; Z and N computed from result; C=0.
  - b==0: result = all ones, V=1, Z=0, N=1.
- Undefined: op 111 behaves as reserved (above); no DIV state or divider logic is synthesised.

Test Plan (WIDTH=32):
- add a=0x7FFFFFFF, b=1 → after 1 cycle: result 0x80000000, N=1, V=1, C=0, Z=0, gt=0.
- sub a=5, b=5 → result 0, Z=1, C=1, gt=0. sub a=3, b=0xFFFFFFFE → result 5, gt=1, V=0.
- mul a=0x00010000, b=0x00010000 → in_ready low for 32 cycles; out_valid exactly 33 edges after accept; result 0, Z=1, C=V=1.
- Back-pressure: add 1+2 with out_ready low for 3 cycles → result 3 held constant, in_ready=0 during the stall; on the cycle out_ready rises, a queued xor is accepted and its result appears next cycle.
- sll a=1, b=0x000007C0 (shamt 31) → 0x80000000, flags 0. srl a=0x80000000, same b → 1.
- rst pulsed 10 cycles into mul 7×9 → out_valid never rises for that op; the next mul 7×9 gives 63.
